pcileech_eth_tx_coalesce: RTL and testbench

- Upstream feeder of the RMII Ethernet/UDP transmit path.
- Buffers 32-bit result DWORDs from the core FIFO side and presents them on the din / din_empty / din_wr_en / din_ready interface of the Ethernet block.
- Coalesces small bursts into larger UDP payloads: it holds data until a full packet's worth (256 DWORDs) is buffered, a timeout expires, or a flush is requested, then drains continuously.

---
 rtl/pcileech_eth_pkg.sv | 16 +
 rtl/pcileech_eth_tx_ram.sv | 30 +++
 rtl/pcileech_eth_tx_coalesce.sv | 176 +++++++++++++++++
 tb/tb_pcileech_eth_tx_coalesce.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/pcileech_eth_pkg.sv
// rtl/pcileech_eth_pkg.sv - shared types and constants for the Ethernet/UDP transmit path
package pcileech_eth_pkg;

    // Largest UDP payload the Ethernet block emits, in DWORDs; its packet counter uses it too.
    localparam int ETH_UDP_MAX_DWORDS = 256;

    // Width of the coalescing timeout counter.
    localparam int ETH_TX_TIMER_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HOLD  = 2'd1,
        ST_DRAIN = 2'd2
    } eth_tx_state_t;

endpackage

// File: rtl/pcileech_eth_tx_ram.sv
// rtl/pcileech_eth_tx_ram.sv - simple dual-port buffer RAM, sync write, registered read
module pcileech_eth_tx_ram #(
    parameter int DEPTH_LOG2 = 10,
    parameter int WIDTH      = 32
)(
    input  logic                  clk,
    input  logic                  i_wr_en,
    input  logic [DEPTH_LOG2-1:0] i_wr_addr,
    input  logic [WIDTH-1:0]      i_wr_data,
    input  logic                  i_rd_en,
    input  logic [DEPTH_LOG2-1:0] i_rd_addr,
    output logic [WIDTH-1:0]      o_rd_data
);

    logic [WIDTH-1:0] r_mem [0:(1 << DEPTH_LOG2)-1];
    logic [WIDTH-1:0] r_rd_data;

    // Block-RAM style port pair: no reset so the array maps onto a BRAM primitive.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
        if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/pcileech_eth_tx_coalesce.sv
// rtl/pcileech_eth_tx_coalesce.sv - buffers result DWORDs and releases them to the Ethernet block in coalesced bursts
module pcileech_eth_tx_coalesce
    import pcileech_eth_pkg::*;
#(
    parameter int PARAM_DEPTH_LOG2 = 10,
    parameter int PARAM_THRESHOLD  = ETH_UDP_MAX_DWORDS,
    parameter int PARAM_TIMEOUT    = 1000
)(
    input  logic                      clk,
    input  logic                      rst,
    input  logic [31:0]               in_data,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      flush,
    output logic [31:0]               din,
    output logic                      din_empty,
    output logic                      din_wr_en,
    input  logic                      din_ready,
    output logic [PARAM_DEPTH_LOG2:0] level,
    output logic                      overflow
);

    localparam int                        LW         = PARAM_DEPTH_LOG2 + 1;
    localparam int                        AW         = PARAM_DEPTH_LOG2;
    localparam logic [LW-1:0]             LVL_FULL   = LW'(1 << PARAM_DEPTH_LOG2);
    localparam logic [LW-1:0]             LVL_THRESH = LW'(PARAM_THRESHOLD);
    localparam logic [ETH_TX_TIMER_W-1:0] TIMER_LAST = ETH_TX_TIMER_W'(PARAM_TIMEOUT - 1);

    eth_tx_state_t             r_state;
    logic [ETH_TX_TIMER_W-1:0] r_timer;
    logic [AW-1:0]             r_wr_ptr;
    logic [AW-1:0]             r_rd_ptr;
    logic [LW-1:0]             r_ram_cnt;
    logic [LW-1:0]             r_level;
    logic                      r_rd_pend;
    logic                      r_out_valid;
    logic [31:0]               r_out_data;
    logic                      r_wr_en;
    logic                      r_overflow;

    logic                      w_wr;
    logic                      w_pop;
    logic                      w_rd_issue;
    logic [31:0]               w_ram_rdata;

    // in_ready depends only on the registered level, never on in_valid.
    assign in_ready   = (r_level < LVL_FULL);
    assign w_wr       = in_valid && in_ready;
    // The strobe cycle itself is the pop: the head word leaves on it.
    assign w_pop      = r_wr_en;
    // Refill the head whenever it is (or is about to become) empty and a read is not already in flight.
    assign w_rd_issue = (r_ram_cnt != '0) && !r_rd_pend && (!r_out_valid || w_pop);

    assign din        = r_out_data;
    assign din_empty  = !((r_state == ST_DRAIN) && r_out_valid);
    assign din_wr_en  = r_wr_en;
    assign level      = r_level;
    assign overflow   = r_overflow;

    pcileech_eth_tx_ram #(
        .DEPTH_LOG2 (PARAM_DEPTH_LOG2),
        .WIDTH      (32)
    ) u_ram (
        .clk       (clk),
        .i_wr_en   (w_wr),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data (in_data),
        .i_rd_en   (w_rd_issue),
        .i_rd_addr (r_rd_ptr),
        .o_rd_data (w_ram_rdata)
    );

    // RAM pointers and the count of words still sitting in the RAM (not yet read out).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_ram_cnt <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_rd_issue) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_wr, w_rd_issue})
                2'b10:   r_ram_cnt <= r_ram_cnt + LW'(1);
                2'b01:   r_ram_cnt <= r_ram_cnt - LW'(1);
                default: r_ram_cnt <= r_ram_cnt;
            endcase
        end
    end

    // Total words held (RAM, in-flight read and head register); write+pop together leaves it unchanged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_level <= '0;
        end else begin
            case ({w_wr, w_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    // FWFT head register: loaded one cycle after a read is issued, emptied on the pop strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_pend   <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else begin
            r_rd_pend <= w_rd_issue;
            if (r_rd_pend) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_ram_rdata;
            end else if (w_pop) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    // Registered single-cycle pop strobe; the self-gating term forbids back-to-back strobes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_en <= 1'b0;
        end else begin
            r_wr_en <= din_ready && !din_empty && !r_wr_en;
        end
    end

    // Sticky drop indicator for a word offered while the buffer was full.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_overflow <= 1'b0;
        end else if (in_valid && !in_ready) begin
            r_overflow <= 1'b1;
        end
    end

    // Coalescing FSM: hold a partial burst until threshold, timeout or flush, then drain until empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_timer <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_timer <= '0;
                    if (w_wr) begin
                        r_state <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    r_timer <= r_timer + ETH_TX_TIMER_W'(1);
                    if ((r_level >= LVL_THRESH) || (r_timer == TIMER_LAST) || flush) begin
                        r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    // A word landing on the very cycle the buffer empties starts a fresh hold window.
                    if ((r_level == '0) && !r_wr_en) begin
                        r_timer <= '0;
                        r_state <= w_wr ? ST_HOLD : ST_IDLE;
                    end
                end
                default: begin
                    r_timer <= '0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pcileech_eth_tx_coalesce.sv
// tb/tb_pcileech_eth_tx_coalesce.sv - directed self-checking bench for the Ethernet TX coalescer
module tb_pcileech_eth_tx_coalesce;

    logic        clk;
    logic        rst;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic        flush;
    logic [31:0] din;
    logic        din_empty;
    logic        din_wr_en;
    logic        din_ready;
    logic [10:0] level;
    logic        overflow;

    int          n_checks = 0;
    int          n_errors = 0;
    int          n_b2b    = 0;
    logic        prev_wr  = 1'b0;
    logic [31:0] got[$];

    pcileech_eth_tx_coalesce #(
        .PARAM_DEPTH_LOG2 (10),
        .PARAM_THRESHOLD  (256),
        .PARAM_TIMEOUT    (1000)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .flush     (flush),
        .din       (din),
        .din_empty (din_empty),
        .din_wr_en (din_wr_en),
        .din_ready (din_ready),
        .level     (level),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp_v);
        end
    endtask

    // One clock; sample 1 time unit after the edge and capture any strobed word.
    task automatic step();
        @(posedge clk);
        #1;
        if (din_wr_en === 1'b1) begin
            got.push_back(din);
            if (prev_wr) n_b2b++;
        end
        prev_wr = din_wr_en;
    endtask

    task automatic push_seq(input logic [31:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_data  = base + i;
            step();
        end
        in_valid = 1'b0;
    endtask

    task automatic pulse_flush();
        flush = 1'b1;
        step();
        flush = 1'b0;
    endtask

    task automatic wait_words(input int n, input int budget);
        for (int k = 0; k < budget && got.size() < n; k++) step();
    endtask

    task automatic check_seq(input string tag, input logic [31:0] base, input int n);
        int bad = 0;
        check({tag, " count"}, got.size(), n);
        for (int i = 0; i < got.size(); i++) begin
            if (i >= n || got[i] !== base + i) bad++;
        end
        check({tag, " data"}, bad, 0);
    endtask

    initial begin
        int n;
        int bad;
        rst       = 1'b1;
        in_data   = '0;
        in_valid  = 1'b0;
        flush     = 1'b0;
        din_ready = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst din_empty", din_empty, 1);
        check("rst din_wr_en", din_wr_en, 0);
        check("rst in_ready", in_ready, 1);
        check("rst overflow", overflow, 0);
        check("rst din", din, 0);
        check("rst level", level, 0);
        rst = 1'b0;
        step();

        // Flush while idle does nothing
        pulse_flush();
        step();
        check("idle flush empty", din_empty, 1);

        // Partial burst released by timeout: first accept on edge 1, release on edge 1001
        din_ready = 1'b1;
        got.delete();
        push_seq(32'h0000_00A1, 3);
        n = 0;
        while (din_empty && n < 1100) begin
            step();
            n++;
        end
        check("t1 hold cycles", n, 998);
        wait_words(3, 50);
        check_seq("t1", 32'h0000_00A1, 3);
        repeat (4) step();
        check("t1 level", level, 0);

        // Threshold release: 256 words, DRAIN on the edge after level hits 256, then 3-cycle cadence
        got.delete();
        push_seq(32'h2000_0000, 256);
        check("t2 held", din_empty, 1);
        step();
        check("t2 release", din_empty, 0);
        n = 0;
        while (got.size() < 256 && n < 2000) begin
            step();
            n++;
        end
        check("t2 drain cycles", n, 766);
        check_seq("t2", 32'h2000_0000, 256);
        repeat (4) step();
        check("t2 level", level, 0);

        // Flush release of a small burst
        got.delete();
        push_seq(32'h3000_0000, 5);
        repeat (9) step();
        check("t3 before flush", din_empty, 1);
        pulse_flush();
        check("t3 flush release", din_empty, 0);
        wait_words(5, 50);
        check_seq("t3", 32'h3000_0000, 5);
        repeat (4) step();

        // Full buffer, overflow, then complete drain
        din_ready = 1'b0;
        got.delete();
        check("t4 overflow pre", overflow, 0);
        push_seq(32'h4000_0000, 1023);
        check("t4 ready at 1023", in_ready, 1);
        push_seq(32'h4000_0000 + 1023, 1);
        check("t4 level full", level, 1024);
        check("t4 ready full", in_ready, 0);
        in_valid = 1'b1;
        in_data  = 32'hDEAD_BEEF;
        step();
        in_valid = 1'b0;
        check("t4 overflow", overflow, 1);
        check("t4 level kept", level, 1024);
        din_ready = 1'b1;
        wait_words(1024, 4000);
        repeat (10) step();
        check_seq("t4", 32'h4000_0000, 1024);
        check("t4 level end", level, 0);
        check("t4 overflow sticky", overflow, 1);

        // Concurrent push and pop every 4 cycles, more than one pointer wrap
        din_ready = 1'b0;
        got.delete();
        push_seq(32'h6000_0000, 8);
        pulse_flush();
        bad = 0;
        for (int j = 0; j < 1100; j++) begin
            in_valid  = 1'b1;
            in_data   = 32'h6000_0008 + j;
            din_ready = 1'b1;
            step();
            in_valid  = 1'b0;
            din_ready = 1'b0;
            repeat (3) step();
            if (level !== 11'd8) bad++;
        end
        check("t6 level const", bad, 0);
        din_ready = 1'b1;
        wait_words(1108, 200);
        check_seq("t6", 32'h6000_0000, 1108);
        repeat (4) step();

        // Asynchronous reset during DRAIN with a strobe in progress
        din_ready = 1'b0;
        push_seq(32'h7000_0000, 100);
        pulse_flush();
        din_ready = 1'b1;
        n = 0;
        while (din_wr_en !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        check("t5 strobe seen", din_wr_en, 1);
        rst = 1'b1;
        #1;
        check("t5 async empty", din_empty, 1);
        check("t5 async wr_en", din_wr_en, 0);
        check("t5 async level", level, 0);
        step();
        step();
        rst = 1'b0;
        got.delete();
        prev_wr = 1'b0;
        check("t5 overflow cleared", overflow, 0);
        push_seq(32'h0000_0055, 1);
        pulse_flush();
        repeat (30) step();
        check("t5 one word", got.size(), 1);
        check("t5 word", (got.size() > 0) ? got[0] : 32'hFFFF_FFFF, 32'h0000_0055);

        check("no b2b strobes", n_b2b, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
